// File: rtl/note_lane_queue.sv
// Multi-lane note queue: notes shift toward slot 0 on step and are judged in a
// hit window at the slot-0 end. Outputs hit/miss pulses and a saturating combo count.
module note_lane_queue #(
    parameter int LANES  = 2,
    parameter int CODE_W = 2,
    parameter int DEPTH  = 16,
    parameter int WIN    = 3
) (
    input  logic                            clk_div,
    input  logic                            rst,
    input  logic                            step,
    input  logic                            flush,
    input  logic [LANES*CODE_W-1:0]         note_in,
    input  logic [LANES-1:0]                hit,
    output logic [LANES*DEPTH*CODE_W-1:0]   lane_q,
    output logic [LANES-1:0]                hit_ok,
    output logic [LANES*CODE_W-1:0]         hit_code,
    output logic [LANES-1:0]                hit_bad,
    output logic [LANES-1:0]                miss,
    output logic [15:0]                     combo
);

    // A window wider than the lane would index past the array; clamp it.
    localparam int WN = (WIN < DEPTH) ? WIN : DEPTH;

    logic [LANES*DEPTH*CODE_W-1:0] work;
    logic [LANES*DEPTH*CODE_W-1:0] lane_d;
    logic [LANES-1:0]              found;
    logic [LANES-1:0]              ok_d;
    logic [LANES-1:0]              bad_d;
    logic [LANES-1:0]              miss_d;
    logic [LANES*CODE_W-1:0]       code_d;
    logic [16:0]                   sum;
    logic [15:0]                   combo_d;

    always_comb begin
        work    = lane_q;
        lane_d  = lane_q;
        found   = '0;
        ok_d    = '0;
        bad_d   = '0;
        miss_d  = '0;
        code_d  = '0;
        sum     = '0;
        combo_d = combo;

        // Judge on pre-edge contents; the cleared array is what gets shifted.
        for (int k = 0; k < LANES; k++) begin
            for (int s = 0; s < WN; s++) begin
                if (hit[k] && !found[k] && (work[(k*DEPTH+s)*CODE_W +: CODE_W] != '0)) begin
                    found[k] = 1'b1;
                    code_d[k*CODE_W +: CODE_W] = work[(k*DEPTH+s)*CODE_W +: CODE_W];
                    work[(k*DEPTH+s)*CODE_W +: CODE_W] = '0;
                end
            end
            ok_d[k]  = hit[k] & found[k];
            bad_d[k] = hit[k] & ~found[k];
        end

        lane_d = work;
        if (step) begin
            for (int k = 0; k < LANES; k++) begin
                miss_d[k] = |work[(k*DEPTH)*CODE_W +: CODE_W];
                for (int s = 0; s < DEPTH-1; s++) begin
                    lane_d[(k*DEPTH+s)*CODE_W +: CODE_W] = work[(k*DEPTH+s+1)*CODE_W +: CODE_W];
                end
                lane_d[(k*DEPTH+DEPTH-1)*CODE_W +: CODE_W] = note_in[k*CODE_W +: CODE_W];
            end
        end

        sum = {1'b0, combo};
        for (int k = 0; k < LANES; k++) begin
            sum = sum + 17'(ok_d[k]);
        end

        if ((|bad_d) || (|miss_d)) begin
            combo_d = '0;
        end else if (sum[16]) begin
            combo_d = 16'hFFFF;
        end else begin
            combo_d = sum[15:0];
        end

        if (flush) begin
            lane_d  = '0;
            ok_d    = '0;
            bad_d   = '0;
            miss_d  = '0;
            code_d  = '0;
            combo_d = '0;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            lane_q   <= '0;
            hit_ok   <= '0;
            hit_code <= '0;
            hit_bad  <= '0;
            miss     <= '0;
            combo    <= '0;
        end else begin
            lane_q   <= lane_d;
            hit_ok   <= ok_d;
            hit_code <= code_d;
            hit_bad  <= bad_d;
            miss     <= miss_d;
            combo    <= combo_d;
        end
    end

endmodule
